serv_stoc_engine: RTL and testbench
===================================

SERV_STOC_ENGINE -- requirements
Module: serv_stoc_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent stochastic lanes (1..16).
REQ-002 SHALL have parameter N, default 8: binary operand precision (4..12); stream length L = 2^N-1 cycles.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: i_en  in  1  clock enable; low freezes all state.
REQ-006 SHALL have ports: i_start  in  1  request one conversion-compute-count run.
REQ-007 SHALL have ports: i_op  in  3  operation code, sampled on accept.
REQ-008 SHALL have ports: i_corr  in  1  1 = B stream shares A's LFSR (correlated); sampled on accept.
REQ-009 SHALL have ports: i_a, i_b  in  LANES*N  unsigned operands, lane 0 at LSBs; sampled on accept.
REQ-010 SHALL have ports: o_busy  out  1  high in RUN and DONE.
REQ-011 SHALL have ports: o_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports: o_result  out  LANES*N  per-lane ones count of the result stream.
REQ-013 SHALL have ports: o_cmp  out  LANES  per-lane flag, count(A stream) > count(B stream).

Function
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL accept i_start only in IDLE with i_en=1, latching op, corr, a and b, clearing counters, loading LFSR seeds and entering RUN.
REQ-016 SHALL ignore i_start in RUN and DONE.
REQ-017 SHALL use three maximal-length N-bit LFSRs: LA (seed 1), LB (seed 2^(N-1)) and LS (seed all-ones), each advancing once per enabled RUN cycle.
REQ-018 SHALL generate stream bits sa = (LA <= a) and sb = (corr ? LA : LB) <= b, plus select bit ss = (LS < 2^(N-1)).
REQ-019 SHALL compute the result bit r as: op 000 AND (sa&sb); 001 OR; 010 XOR; 011 MUX (ss ? sa : sb); 100 ANDN (sa&~sb); 101 PASS (sa); 110/111 reserved, r=0.
REQ-020 SHALL maintain per-lane N-bit counters cnt_r, cnt_a and cnt_b, each adding its bit every enabled RUN cycle; counters SHALL NOT overflow (max L = 2^N-1).
REQ-021 SHALL run RUN for exactly L enabled cycles, tracked by an N-bit cycle counter, then enter DONE.
REQ-022 SHALL, on entry to DONE, register o_result = cnt_r and o_cmp = (cnt_a > cnt_b), and assert o_valid for exactly one cycle.
REQ-023 SHALL return from DONE to IDLE on the next enabled cycle.
REQ-024 SHALL, with continuous i_en, assert o_valid 2^N cycles after the edge that accepted i_start.
REQ-025 SHALL, when i_en=0, hold state, LFSRs and counters; o_valid SHALL NOT be stretched (it is forced low while i_en=0).
REQ-026 SHALL hold o_result and o_cmp between completions.
REQ-027 SHALL give exact results for the full-period property: PASS returns a; with corr=1, AND returns min(a,b), OR returns max(a,b) and XOR returns |a-b|.

Reset
REQ-028 SHALL, on i_rst high at a rising edge (regardless of i_en), set state IDLE, o_busy=0, o_valid=0, o_result=0, o_cmp=0, all counters 0 and LFSRs to their seeds.
REQ-029 SHALL abort an in-progress run on reset mid-RUN, producing no o_valid and leaving the previous o_result cleared to 0.

Structure
REQ-030 SHALL define opcodes, LFSR tap constants for N=4..12 and seed constants in shared package serv_stoc_pkg.
REQ-031 SHALL instantiate the LFSR as sub-module serv_stoc_lfsr (parameter N; ports for load, seed, advance and state), three instances, shared by all lanes.

Verification
REQ-032 SHALL cover: N=8, op=PASS, a=200 -> o_valid at cycle 256 after accept, o_result=200.
REQ-033 SHALL cover: corr=1, a=100, b=60: AND -> 60; OR -> 100; XOR -> 40; o_cmp=1 in each case.
REQ-034 SHALL cover: corr=0, op=AND with a=b=255 -> 255 and with a=0 -> 0; MUX with corr=1 and a=b=77 -> 77.
REQ-035 SHALL cover: i_en low for 10 cycles mid-RUN -> o_valid delayed by exactly 10 cycles with an unchanged result; i_start during RUN is ignored.
REQ-036 SHALL cover: i_rst at cycle 50 of RUN -> no o_valid, all outputs 0, a new i_start in the next cycle is accepted.
REQ-037 SHALL cover: LANES=4 with distinct per-lane PASS operands {1,128,254,255} -> each lane returns its own value; op=110 -> o_result=0.

Source files
------------

// File: rtl/serv_stoc_pkg.sv
// serv_stoc_pkg -- shared definitions for the stochastic compute engine.
//
// Contents:
//   op_e        result-stream operation codes
//   state_e     engine FSM states
//   lfsr_taps() maximal-length Fibonacci tap masks for N = 4..12
//   seed_a/b/s  LFSR seed values for the A, B and select generators
//
// Tap masks are for a left-shifting Fibonacci LFSR whose feedback bit is the
// XOR of the masked state bits and enters at bit 0. Each mask gives a period
// of 2^N-1 and visits every nonzero state once per period.
package serv_stoc_pkg;

  localparam int N_MIN = 4;
  localparam int N_MAX = 12;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_MUX  = 3'b011,
    OP_ANDN = 3'b100,
    OP_PASS = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [N_MAX-1:0] lfsr_taps(input int n);
    case (n)
      4:       return 12'h00C;  // x^4  + x^3 + 1
      5:       return 12'h014;  // x^5  + x^3 + 1
      6:       return 12'h030;  // x^6  + x^5 + 1
      7:       return 12'h060;  // x^7  + x^6 + 1
      8:       return 12'h0B8;  // x^8  + x^6 + x^5 + x^4 + 1
      9:       return 12'h110;  // x^9  + x^5 + 1
      10:      return 12'h240;  // x^10 + x^7 + 1
      11:      return 12'h500;  // x^11 + x^9 + 1
      12:      return 12'h829;  // x^12 + x^6 + x^4 + x + 1
      default: return 12'h000;
    endcase
  endfunction

  // A starts at 1.
  function automatic logic [N_MAX-1:0] seed_a(input int n);
    logic [N_MAX-1:0] v;
    v = '0;
    if (n > 0) v[0] = 1'b1;
    return v;
  endfunction

  // B starts at 2^(N-1), a different phase of the same sequence as A.
  function automatic logic [N_MAX-1:0] seed_b(input int n);
    logic [N_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i == n - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // The select generator starts at all-ones.
  function automatic logic [N_MAX-1:0] seed_s(input int n);
    logic [N_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/serv_stoc_lfsr.sv
// serv_stoc_lfsr -- N-bit maximal-length Fibonacci LFSR.
//
// Ports:
//   clk      rising-edge clock
//   load     load seed into the register (has priority over advance)
//   seed     value loaded when load is high
//   advance  step the sequence by one
//   state    current LFSR value
//
// There is no reset port. The engine pulses load during its own reset, so the
// register comes out of reset holding its seed.
module serv_stoc_lfsr
  import serv_stoc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         advance,
  output logic [N-1:0] state
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  logic fb;

  assign fb = ^(state & TAPS);

  // NOTE: clocked state is always written with <= so that every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= {state[N-2:0], fb};
    end
  end

endmodule

// File: rtl/serv_stoc_engine.sv
// serv_stoc_engine -- multi-lane stochastic arithmetic engine.
//
// Each run converts the binary operands of every lane into unipolar stochastic
// bit streams. The streams are compared against shared LFSRs for one full
// LFSR period, L = 2^N-1 cycles. The selected bitwise operation is applied,
// and the ones in the result stream are counted.
//
// Ports:
//   clk       rising-edge clock
//   i_rst     synchronous active-high reset (effective regardless of i_en)
//   i_en      clock enable; low freezes state, LFSRs and counters
//   i_start   start a run (accepted only in IDLE with i_en high)
//   i_op      operation code (op_e), latched on accept
//   i_corr    1: B stream compares against A's LFSR; latched on accept
//   i_a, i_b  per-lane N-bit operands, lane 0 at the LSBs; latched on accept
//   o_busy    high while a run is in progress (RUN or DONE)
//   o_valid   one-cycle completion pulse, masked while i_en is low
//   o_result  per-lane ones count of the result stream
//   o_cmp     per-lane flag: ones(A stream) > ones(B stream)
//
// Timing, with i_en held high: the accept edge loads the seeds. The next L
// edges each consume one stream bit. A further edge leaves DONE and publishes
// o_result, o_cmp and o_valid. The pulse is therefore visible 2^N edges after
// the accept.
module serv_stoc_engine
  import serv_stoc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic               i_corr,
  input  logic [LANES*N-1:0] i_a,
  input  logic [LANES*N-1:0] i_b,
  output logic               o_busy,
  output logic               o_valid,
  output logic [LANES*N-1:0] o_result,
  output logic [LANES-1:0]   o_cmp
);

  localparam logic [N-1:0] SEED_A   = N'(seed_a(N));
  localparam logic [N-1:0] SEED_B   = N'(seed_b(N));
  localparam logic [N-1:0] SEED_S   = N'(seed_s(N));
  // The select threshold 2^(N-1) has the same value as B's seed.
  localparam logic [N-1:0] SEL_HALF = SEED_B;
  // Index of the last RUN cycle; the cycle counter runs 0 .. L-1.
  localparam logic [N-1:0] CYC_LAST = N'((1 << N) - 2);

  state_e                      state_q, state_d;
  op_e                         op_q;
  logic                        corr_q;
  logic [LANES-1:0][N-1:0]     a_q, b_q;
  logic [LANES-1:0][N-1:0]     cnt_r_q, cnt_a_q, cnt_b_q;
  logic [LANES-1:0][N-1:0]     res_q;
  logic [LANES-1:0]            cmp_q;
  logic [N-1:0]                cyc_q;
  logic                        valid_q;

  logic                        accept, step, run_last, lfsr_load;
  logic [N-1:0]                la, lb, ls;
  logic [LANES-1:0]            sa, sb, r;
  logic                        ss;

  assign accept    = i_en && (state_q == ST_IDLE) && i_start;
  assign step      = i_en && (state_q == ST_RUN);
  assign run_last  = step && (cyc_q == CYC_LAST);
  assign lfsr_load = i_rst || accept;

  assign o_busy   = (state_q != ST_IDLE);
  assign o_valid  = valid_q && i_en;
  assign o_result = res_q;
  assign o_cmp    = cmp_q;

  // Three generators are shared by all lanes. After a full period each one
  // has returned to its seed. The explicit load on accept still matters after
  // an aborted run.
  serv_stoc_lfsr #(.N(N)) u_lfsr_a (
    .clk     (clk),
    .load    (lfsr_load),
    .seed    (SEED_A),
    .advance (step),
    .state   (la)
  );

  serv_stoc_lfsr #(.N(N)) u_lfsr_b (
    .clk     (clk),
    .load    (lfsr_load),
    .seed    (SEED_B),
    .advance (step),
    .state   (lb)
  );

  serv_stoc_lfsr #(.N(N)) u_lfsr_s (
    .clk     (clk),
    .load    (lfsr_load),
    .seed    (SEED_S),
    .advance (step),
    .state   (ls)
  );

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (run_last) state_d = ST_DONE;
      ST_DONE: if (i_en)     state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Stream generation and the per-lane result bit. Because the LFSR sweeps
  // 1..L, (lfsr <= x) is high for exactly x cycles of a period.
  always_comb begin
    sa = '0;
    sb = '0;
    r  = '0;
    ss = (ls < SEL_HALF);
    for (int i = 0; i < LANES; i++) begin
      sa[i] = (la <= a_q[i]);
      sb[i] = ((corr_q ? la : lb) <= b_q[i]);
      case (op_q)
        OP_AND:  r[i] = sa[i] & sb[i];
        OP_OR:   r[i] = sa[i] | sb[i];
        OP_XOR:  r[i] = sa[i] ^ sb[i];
        OP_MUX:  r[i] = ss ? sa[i] : sb[i];
        OP_ANDN: r[i] = sa[i] & ~sb[i];
        OP_PASS: r[i] = sa[i];
        default: r[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      corr_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_r_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      cmp_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_en) begin
      state_q <= state_d;
      // The pulse is set on the DONE exit edge and cleared on the next enabled
      // edge. While i_en is low it is held but masked at the port.
      valid_q <= (state_q == ST_DONE);

      if (accept) begin
        op_q    <= op_e'(i_op);
        corr_q  <= i_corr;
        a_q     <= i_a;
        b_q     <= i_b;
        cnt_r_q <= '0;
        cnt_a_q <= '0;
        cnt_b_q <= '0;
        cyc_q   <= '0;
      end else if (step) begin
        cyc_q <= cyc_q + N'(1);
        for (int i = 0; i < LANES; i++) begin
          cnt_r_q[i] <= cnt_r_q[i] + N'(r[i]);
          cnt_a_q[i] <= cnt_a_q[i] + N'(sa[i]);
          cnt_b_q[i] <= cnt_b_q[i] + N'(sb[i]);
        end
      end

      if (state_q == ST_DONE) begin
        res_q <= cnt_r_q;
        for (int i = 0; i < LANES; i++) begin
          cmp_q[i] <= (cnt_a_q[i] > cnt_b_q[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_stoc_engine.sv
// tb_serv_stoc_engine -- scoreboard testbench for serv_stoc_engine (LANES=4, N=8).
//
// The driver issues runs and pushes the expected result, compare flags and
// completion cycle into a queue. A negedge monitor pops one entry on every
// o_valid pulse and compares it. Directed cases use closed-form answers
// (min/max/|a-b|/a). Random cases use a reference model that counts stream
// bits over one period of the LFSR state sequence.
module tb_serv_stoc_engine;

  localparam int LANES = 4;
  localparam int N     = 8;
  localparam int L     = (1 << N) - 1;
  localparam int W     = LANES * N;

  logic           clk;
  logic           i_rst, i_en, i_start, i_corr;
  logic [2:0]     i_op;
  logic [W-1:0]   i_a, i_b;
  logic           o_busy, o_valid;
  logic [W-1:0]   o_result;
  logic [LANES-1:0] o_cmp;

  serv_stoc_engine #(.LANES(LANES), .N(N)) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_corr   (i_corr),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_cmp    (o_cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     r;
    logic [LANES-1:0] c;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference LFSR sequence and the phase offsets of the B and select
  // generators within it.
  int seq [L];
  int ob, os;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [N-1:0] v);
    return {LANES{v}};
  endfunction

  // With full-period streams, ones(A) = a and ones(B) = b for either corr
  // setting, so the compare flag is a plain per-lane a > b.
  function automatic logic [LANES-1:0] cmpv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [LANES-1:0] c;
    for (int l = 0; l < LANES; l++) c[l] = (a[l*N +: N] > b[l*N +: N]);
    return c;
  endfunction

  // Behavioural model: count result bits over one period of the sequence.
  task automatic model(input logic [2:0] op, input bit corr, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] er,
                       output logic [LANES-1:0] ec);
    for (int l = 0; l < LANES; l++) begin
      int av, bv, cr, ca, cbb;
      av = int'(a[l*N +: N]);
      bv = int'(b[l*N +: N]);
      cr = 0; ca = 0; cbb = 0;
      for (int t = 0; t < L; t++) begin
        int la, lb, ls;
        bit xa, xb, xs, xr;
        la = seq[t];
        lb = corr ? la : seq[(t + ob) % L];
        ls = seq[(t + os) % L];
        xa = (la <= av);
        xb = (lb <= bv);
        xs = (ls < (1 << (N - 1)));
        case (op)
          3'b000:  xr = xa & xb;
          3'b001:  xr = xa | xb;
          3'b010:  xr = xa ^ xb;
          3'b011:  xr = xs ? xa : xb;
          3'b100:  xr = xa & ~xb;
          3'b101:  xr = xa;
          default: xr = 1'b0;
        endcase
        cr  += int'(xr);
        ca  += int'(xa);
        cbb += int'(xb);
      end
      er[l*N +: N] = N'(cr);
      ec[l]        = (ca > cbb);
    end
  endtask

  // Called just after a negedge. The start is accepted on the next posedge.
  task automatic issue(input logic [2:0] op, input bit corr, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er,
                       input logic [LANES-1:0] ec, input int extra, input bit expect_done);
    exp_t e;
    i_op    = op;
    i_corr  = corr;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    e.r     = er;
    e.c     = ec;
    e.cyc   = cyc + 1 + (1 << N) + extra;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 700 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d completions still pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_model(input logic [2:0] op, input bit corr, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0]     er;
    logic [LANES-1:0] ec;
    model(op, corr, a, b, er, ec);
    issue(op, corr, a, b, er, ec, 0, 1'b1);
    wait_done();
  endtask

  // Monitor: every o_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 with result %0h, expected no completion", o_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",  o_result, e.r);
        check("cmp",     o_cmp,    e.c);
        check("latency", cyc,      e.cyc);
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    int s;

    // Build the A sequence from seed 1 (taps at bits 7,5,4,3, shift left).
    s = 1;
    for (int t = 0; t < L; t++) begin
      int fb;
      seq[t] = s;
      fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
      s  = ((s << 1) | fb) & L;
    end
    ob = 0;
    os = 0;
    for (int t = 0; t < L; t++) begin
      if (seq[t] == (1 << (N - 1))) ob = t;
      if (seq[t] == L)              os = t;
    end

    i_rst = 1'b1; i_en = 1'b1; i_start = 1'b0;
    i_op = 3'b000; i_corr = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   o_busy,   1'b0);
    check("rst_valid",  o_valid,  1'b0);
    check("rst_result", o_result, '0);
    check("rst_cmp",    o_cmp,    '0);
    i_rst = 1'b0;
    @(negedge clk);

    // PASS a=200 -> 200, visible 256 edges after accept.
    b = {8'd10, 8'd220, 8'd200, 8'd0};
    issue(3'b101, 1'b0, rep(8'd200), b, rep(8'd200), cmpv(rep(8'd200), b), 0, 1'b1);
    wait_done();

    // Correlated a=100, b=60: AND=min, OR=max, XOR=|a-b|.
    issue(3'b000, 1'b1, rep(8'd100), rep(8'd60), rep(8'd60),  4'hF, 0, 1'b1);
    wait_done();
    issue(3'b001, 1'b1, rep(8'd100), rep(8'd60), rep(8'd100), 4'hF, 0, 1'b1);
    wait_done();
    issue(3'b010, 1'b1, rep(8'd100), rep(8'd60), rep(8'd40),  4'hF, 0, 1'b1);
    wait_done();

    // Uncorrelated AND at the extremes, and MUX of identical streams.
    issue(3'b000, 1'b0, rep(8'd255), rep(8'd255), rep(8'd255), 4'h0, 0, 1'b1);
    wait_done();
    issue(3'b000, 1'b0, rep(8'd0), rep(8'd255), rep(8'd0), 4'h0, 0, 1'b1);
    wait_done();
    issue(3'b011, 1'b1, rep(8'd77), rep(8'd77), rep(8'd77), 4'h0, 0, 1'b1);
    wait_done();

    // Distinct lanes under PASS, then a reserved opcode.
    a = {8'd255, 8'd254, 8'd128, 8'd1};
    b = {8'd0, 8'd255, 8'd127, 8'd1};
    issue(3'b101, 1'b0, a, b, a, cmpv(a, b), 0, 1'b1);
    wait_done();
    issue(3'b110, 1'b0, a, b, '0, cmpv(a, b), 0, 1'b1);
    wait_done();

    // Start held during RUN is ignored. Ten disabled cycles delay the
    // completion by exactly ten cycles.
    a = {8'd40, 8'd30, 8'd20, 8'd10};
    issue(3'b101, 1'b0, a, rep(8'd25), a, cmpv(a, rep(8'd25)), 10, 1'b1);
    repeat (100) @(negedge clk);
    check("busy_run", o_busy, 1'b1);
    i_op = 3'b110; i_a = '0; i_start = 1'b1;
    repeat (5) @(negedge clk);
    i_start = 1'b0;
    i_en = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_paused", o_busy, 1'b1);
    i_en = 1'b1;
    wait_done();

    // Reset 50 cycles into a run: no completion, outputs cleared, restart taken.
    issue(3'b101, 1'b0, rep(8'd99), rep(8'd1), '0, '0, 0, 1'b0);
    repeat (49) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort_busy",   o_busy,   1'b0);
    check("abort_valid",  o_valid,  1'b0);
    check("abort_result", o_result, '0);
    check("abort_cmp",    o_cmp,    '0);
    issue(3'b100, 1'b1, rep(8'd150), rep(8'd50), rep(8'd100), 4'hF, 0, 1'b1);
    check("restart_busy", o_busy, 1'b1);
    wait_done();

    // Randomized operations against the reference model.
    for (int n = 0; n < 12; n++) begin
      run_model(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
